// File: rtl/cordic_ci_sequencer.sv
// Multicycle custom-instruction front-end for the pipelined CORDIC core:
// latches the operand, clocks the core until its pipeline flushes, then returns the result.
module cordic_ci_sequencer #(
    parameter int W   = 32,
    parameter int LAT = 19,
    parameter int CW  = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         start,
    input  logic [W-1:0] dataa,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         overrun,
    output logic [W-1:0] core_dataa,
    output logic         core_clk_en,
    input  logic [W-1:0] core_result
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CAPT,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(LAT - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    // NOTE: combinational so the core advances on exactly the same enabled edges that the counter does.
    assign core_clk_en = (state == RUN) && clk_en;

    // NOTE: all state, including the operand and result registers, uses non-blocking assignments and is cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            result     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            core_dataa <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        core_dataa <= dataa;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (start) overrun <= 1'b1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) state <= CAPT;
                end
                CAPT: begin
                    if (start) overrun <= 1'b1;
                    result <= core_result;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    done <= 1'b0;
                    // A start in the done cycle is accepted immediately, with no idle gap.
                    if (start) begin
                        core_dataa <= dataa;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_ci_sequencer.sv
// Scoreboard bench for cordic_ci_sequencer with a behavioural CORDIC core model
// and a cycle-budget reference model of the custom-instruction protocol.
module tb_cordic_ci_sequencer;

    localparam int W   = 32;
    localparam int LAT = 19;
    localparam int CW  = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clk_en = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dataa = '0;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic         overrun;
    logic [W-1:0] core_dataa;
    logic         core_clk_en;
    logic [W-1:0] core_result = 32'hDEADBEEF;

    int total = 0;
    int bad   = 0;

    cordic_ci_sequencer #(.W(W), .LAT(LAT), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .start      (start),
        .dataa      (dataa),
        .result     (result),
        .done       (done),
        .busy       (busy),
        .overrun    (overrun),
        .core_dataa (core_dataa),
        .core_clk_en(core_clk_en),
        .core_result(core_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core model: output is operand+1 once exactly LAT enabled edges have seen a stable operand.
    logic [W-1:0] snap_data, prev_data;
    logic         snap_en;
    int           en_cnt = 0;

    always @(negedge clk) begin
        snap_data = core_dataa;
        snap_en   = core_clk_en;
    end

    always @(posedge clk) begin
        if (snap_data !== prev_data) en_cnt = 0;
        prev_data = snap_data;
        if (snap_en === 1'b1) en_cnt++;
        core_result <= (en_cnt == LAT) ? prev_data + 1'b1 : 32'hDEADBEEF;
    end

    // Reference model: an accepted operation owns the next LAT+1 enabled edges,
    // after which done shows for one enabled cycle in which a new start is accepted.
    logic [W-1:0] sb[$];
    int           rem = 0;
    logic         exp_overrun = 1'b0;
    logic         exp_done = 1'b0;
    logic         was_reset = 1'b0;

    always @(posedge clk) begin
        was_reset = rst;
        if (rst) begin
            rem         = 0;
            exp_overrun = 1'b0;
            exp_done    = 1'b0;
            sb.delete();
        end else if (clk_en) begin
            exp_done = 1'b0;
            if (rem > 0) begin
                if (start) exp_overrun = 1'b1;
                rem--;
                if (rem == 0) exp_done = 1'b1;
            end else if (start) begin
                sb.push_back(dataa + 1'b1);
                rem = LAT + 1;
            end
        end
    end

    // Monitor: per-cycle protocol checks, result popped from the scoreboard on each new done.
    logic [W-1:0] held = '0;
    logic         prev_done = 1'b0;
    logic         mon_on = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (was_reset) held = '0;
            check("busy", busy, rem > 0);
            check("done", done, exp_done);
            check("overrun", overrun, exp_overrun);
            check("core_clk_en", core_clk_en, (rem >= 2) && clk_en);
            check("done_busy_excl", done && busy, 1'b0);
            if (done === 1'b1 && prev_done !== 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    held = sb.pop_front();
                    check("result_at_done", result, held);
                end
            end else begin
                check("result_held", result, held);
            end
            prev_done = done;
        end
    end

    task automatic step(input logic s, input logic [W-1:0] d, input logic e, input logic r);
        start  = s;
        dataa  = d;
        clk_en = e;
        rst    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b1, 1'b0);
    endtask

    initial begin
        logic [W-1:0] d;

        // Reset with random other inputs
        step($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 1'b1);
        step($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 1'b1);
        check("rst_result", result, '0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_core_clk_en", core_clk_en, 1'b0);
        check("rst_core_dataa", core_dataa, '0);
        mon_on = 1'b1;

        // Single operation
        step(1'b1, 32'h3F000000, 1'b1, 1'b0);
        idle(25);
        check("single_result", result, 32'h3F000001);

        // Stall of three cycles mid-RUN
        step(1'b1, 32'h3F100000, 1'b1, 1'b0);
        idle(8);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        idle(25);
        check("stall_result", result, 32'h3F100001);

        // Back-to-back start in the done cycle
        step(1'b1, 32'h3F000000, 1'b1, 1'b0);
        idle(20);
        step(1'b1, 32'h3E800000, 1'b1, 1'b0);
        idle(25);
        check("b2b_result", result, 32'h3E800001);

        // Overrun: second start while busy is ignored
        step(1'b1, 32'h3F200000, 1'b1, 1'b0);
        idle(4);
        step(1'b1, 32'h40000000, 1'b1, 1'b0);
        idle(25);
        check("overrun_result", result, 32'h3F200001);
        check("overrun_sticky", overrun, 1'b1);

        // Abort by reset mid-RUN, then a normal operation
        step(1'b1, 32'h12345678, 1'b1, 1'b0);
        idle(10);
        step(1'b0, $urandom, 1'b1, 1'b1);
        check("abort_busy", busy, 1'b0);
        idle(2);
        step(1'b1, 32'h55AA0000, 1'b1, 1'b0);
        idle(25);
        check("abort_next_result", result, 32'h55AA0001);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            d = $urandom;
            if (d == '0) d = 32'h1;
            step($urandom_range(0, 3) == 0, d, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 149) == 0);
        end

        // Drain with a bounded cycle budget
        for (int i = 0; i < 100 && (rem > 0 || sb.size() > 0); i++) idle(1);
        idle(2);
        check("drain_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
